// File: rtl/cla_pkg.sv
// Shared definitions for the multi-precision CLA sequencer.
//   LIMB_W          : width of one adder limb
//   cla_seq_state_t : sequencer FSM states
//   limb_sel()      : pick limb idx out of a (zero-extended) wide operand
package cla_pkg;

  localparam int unsigned LIMB_W    = 32;
  localparam int unsigned MAX_WORDS = 16;
  localparam int unsigned MAX_IDX_W = 4;
  localparam int unsigned SEL_W     = LIMB_W * MAX_WORDS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } cla_seq_state_t;

  // Limb mux shared by both operands; callers zero-extend to SEL_W.
  function automatic logic [LIMB_W-1:0] limb_sel(input logic [SEL_W-1:0]     v,
                                                 input logic [MAX_IDX_W-1:0] idx);
    return v[32'(idx)*LIMB_W +: LIMB_W];
  endfunction

endpackage

// File: rtl/cla32.sv
// 32-bit combinational carry-lookahead adder.
//   A, B : addends
//   Cin  : carry in
//   S    : sum (mod 2^32)
//   Cout : carry out of bit 31
module cla32 (
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Cin,
  output logic [31:0] S,
  output logic        Cout
);

  localparam int unsigned N  = 32;
  localparam int unsigned NG = 8;

  logic [N-1:0]  w_g;
  logic [N-1:0]  w_p;
  logic [N:0]    w_c;
  logic [NG:0]   w_gc;
  logic [NG-1:0] w_gg;
  logic [NG-1:0] w_gp;

  assign w_g = A & B;
  assign w_p = A ^ B;

  // 4-bit groups: group generate/propagate chain the group carries,
  // bit carries inside a group are derived from the group carry-in.
  always_comb begin
    w_gc    = '0;
    w_gg    = '0;
    w_gp    = '0;
    w_c     = '0;
    w_gc[0] = Cin;
    for (int g = 0; g < int'(NG); g++) begin
      w_gg[g] = w_g[4*g+3]
              | (w_p[4*g+3] & w_g[4*g+2])
              | (w_p[4*g+3] & w_p[4*g+2] & w_g[4*g+1])
              | (w_p[4*g+3] & w_p[4*g+2] & w_p[4*g+1] & w_g[4*g]);
      w_gp[g]     = &w_p[4*g +: 4];
      w_gc[g+1]   = w_gg[g] | (w_gp[g] & w_gc[g]);
      w_c[4*g]    = w_gc[g];
      for (int k = 0; k < 3; k++) begin
        w_c[4*g+k+1] = w_g[4*g+k] | (w_p[4*g+k] & w_c[4*g+k]);
      end
    end
    w_c[N] = w_gc[NG];
  end

  assign S    = w_p ^ w_c[N-1:0];
  assign Cout = w_c[N];

endmodule

// File: rtl/cla_mp_seq.sv
// Multi-precision add/subtract sequencer: one cla32 is time-shared over
// WORDS limbs, LSB limb first, with the carry held between limbs.
//   clk, rst_n      : clock, synchronous active-low reset
//   start, sub, cin : request, subtract select, carry in (add only)
//   a, b            : WORDS*32-bit operands, captured on accepted start
//   busy, done      : handshake (busy while not IDLE, done one-cycle pulse)
//   sum, cout, ovf  : result, final carry (1 = no borrow on sub), signed overflow
module cla_mp_seq
  import cla_pkg::*;
#(
  parameter int unsigned WORDS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    sub,
  input  logic                    cin,
  input  logic [LIMB_W*WORDS-1:0] a,
  input  logic [LIMB_W*WORDS-1:0] b,
  output logic                    busy,
  output logic                    done,
  output logic [LIMB_W*WORDS-1:0] sum,
  output logic                    cout,
  output logic                    ovf
);

  localparam int unsigned DATA_W = LIMB_W * WORDS;
  localparam int unsigned IDX_W  = (WORDS > 1) ? $clog2(WORDS) : 1;

  cla_seq_state_t    r_state;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic              r_sub;
  logic [IDX_W-1:0]  r_idx;
  logic              r_carry;
  logic              r_busy;
  logic              r_done;
  logic [DATA_W-1:0] r_sum;
  logic              r_cout;
  logic              r_ovf;

  logic [LIMB_W-1:0] w_a_limb;
  logic [LIMB_W-1:0] w_b_limb;
  logic [LIMB_W-1:0] w_s;
  logic              w_cout;
  logic              w_last;

  // Current limb of each operand; B is inverted for subtraction.
  assign w_a_limb = limb_sel(SEL_W'(r_a), MAX_IDX_W'(r_idx));
  assign w_b_limb = limb_sel(SEL_W'(r_b), MAX_IDX_W'(r_idx)) ^ {LIMB_W{r_sub}};
  assign w_last   = (r_idx == IDX_W'(WORDS - 1));

  cla32 u_cla32 (
    .A    (w_a_limb),
    .B    (w_b_limb),
    .Cin  (r_carry),
    .S    (w_s),
    .Cout (w_cout)
  );

  // Sequencer FSM with registered handshake and result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sub   <= 1'b0;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= RUN;
            r_busy  <= 1'b1;
            r_a     <= a;
            r_b     <= b;
            r_sub   <= sub;
            r_idx   <= '0;
            r_carry <= sub | cin;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
          end
        end
        RUN: begin
          for (int i = 0; i < int'(WORDS); i++) begin
            if (r_idx == IDX_W'(i)) r_sum[i*LIMB_W +: LIMB_W] <= w_s;
          end
          r_carry <= w_cout;
          r_idx   <= r_idx + IDX_W'(1);
          if (w_last) begin
            r_state <= DONE;
            r_done  <= 1'b1;
            r_cout  <= w_cout;
            // Signed overflow: operands agree in sign, result sign differs.
            r_ovf   <= (w_a_limb[LIMB_W-1] == w_b_limb[LIMB_W-1]) &&
                       (w_s[LIMB_W-1] != w_a_limb[LIMB_W-1]);
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_cla_mp_seq.sv
// Testbench for cla_mp_seq: WORDS=4 instance with a scoreboard, plus a
// WORDS=1 instance for the degenerate single-limb case.
module tb_cla_mp_seq;

  localparam int unsigned W  = 4;
  localparam int unsigned DW = 32 * W;

  typedef struct packed {
    logic [DW-1:0] sum;
    logic          cout;
    logic          ovf;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, sub, cin;
  logic [DW-1:0] a, b;
  logic          busy, done, cout, ovf;
  logic [DW-1:0] sum;

  logic          start1, sub1, cin1;
  logic [31:0]   a1, b1;
  logic          busy1, done1, cout1, ovf1;
  logic [31:0]   sum1;

  int            n_checks = 0;
  int            n_fail   = 0;
  int            n_done   = 0;
  int            cyc      = 0;
  exp_t          exp_q[$];
  int            done_cyc[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cla_mp_seq #(.WORDS(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .cin(cin),
    .a(a), .b(b), .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
  );

  cla_mp_seq #(.WORDS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .sub(sub1), .cin(cin1),
    .a(a1), .b(b1), .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1)
  );

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: full-width arithmetic on a 129-bit accumulator.
  function automatic exp_t model(input logic [DW-1:0] av, input logic [DW-1:0] bv,
                                 input logic s, input logic c);
    logic [DW-1:0] bb;
    logic [DW:0]   r;
    exp_t          e;
    bb     = s ? ~bv : bv;
    r      = {1'b0, av} + {1'b0, bb} + (DW+1)'(s ? 1'b1 : c);
    e.sum  = r[DW-1:0];
    e.cout = r[DW];
    e.ovf  = (av[DW-1] == bb[DW-1]) && (r[DW-1] != av[DW-1]);
    return e;
  endfunction

  // Scoreboard: compare every done pulse against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      n_done++;
      done_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("sum", sum, e.sum);
        check("cout", DW'(cout), DW'(e.cout));
        check("ovf", DW'(ovf), DW'(e.ovf));
      end
    end
  end

  task automatic drive_start(input logic [DW-1:0] av, input logic [DW-1:0] bv,
                             input logic s, input logic c);
    @(negedge clk);
    a = av; b = bv; sub = s; cin = c; start = 1'b1;
    exp_q.push_back(model(av, bv, s, c));
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Waits for done (bounded), checking busy and latency along the way.
  task automatic wait_done(input string tag);
    int lat;
    lat = 0;
    while (!done && lat < 40) begin
      check({tag, "_busy_run"}, DW'(busy), 1);
      @(posedge clk);
      #1 lat++;
    end
    check({tag, "_latency"}, DW'(lat), DW'(W));
    check({tag, "_busy_done"}, DW'(busy), 1);
    @(posedge clk);
    #1;
    check({tag, "_done_fall"}, DW'(done), 0);
    check({tag, "_busy_fall"}, DW'(busy), 0);
  endtask

  task automatic run_op(input string tag, input logic [DW-1:0] av, input logic [DW-1:0] bv,
                        input logic s, input logic c);
    drive_start(av, bv, s, c);
    wait_done(tag);
  endtask

  initial begin
    logic [DW-1:0] ones, maxpos;
    int            d0, guard;
    ones   = '1;
    maxpos = {1'b0, {(DW-1){1'b1}}};
    rst_n = 1'b0; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
    start1 = 1'b0; sub1 = 1'b0; cin1 = 1'b0; a1 = '0; b1 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", DW'(busy), 0);
    check("rst_done", DW'(done), 0);
    check("rst_sum", sum, 0);
    check("rst_cout", DW'(cout), 0);
    check("rst_ovf", DW'(ovf), 0);
    rst_n = 1'b1;

    run_op("small_add", 3, 10, 1'b0, 1'b1);
    run_op("limb_carry", 128'hFFFF_FFFF, 1, 1'b0, 1'b0);
    run_op("full_wrap", ones, 0, 1'b0, 1'b1);
    run_op("all_ones", ones, ones, 1'b0, 1'b1);
    run_op("sub_pos", 7, 5, 1'b1, 1'b0);
    run_op("sub_neg", 5, 7, 1'b1, 1'b1);
    run_op("ovf_add", maxpos, 1, 1'b0, 1'b0);
    run_op("sub_ovf", {1'b1, {(DW-1){1'b0}}}, 1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      run_op("rand", {$urandom, $urandom, $urandom, $urandom},
             {$urandom, $urandom, $urandom, $urandom}, 1'($urandom), 1'($urandom));
    end

    // Operand changes during RUN must not disturb the captured values.
    drive_start(128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321,
                128'h0000_0001_FFFF_FFFF_0000_0000_FFFF_FFFF, 1'b0, 1'b1);
    a = ones; b = ones; sub = 1'b1; cin = 1'b0;
    wait_done("opnd_change");

    // start held high: one op per W+2 cycles, no restart in RUN/DONE.
    @(negedge clk);
    a = 100; b = 23; sub = 1'b0; cin = 1'b0; start = 1'b1;
    exp_q.push_back(model(100, 23, 1'b0, 1'b0));
    exp_q.push_back(model(100, 23, 1'b0, 1'b0));
    d0 = n_done;
    done_cyc.delete();
    repeat (10) @(posedge clk);
    #1 start = 1'b0;
    guard = 0;
    while (n_done < d0 + 2 && guard < 40) begin
      @(posedge clk);
      guard++;
    end
    repeat (10) @(posedge clk);
    check("held_start_count", DW'(n_done - d0), 2);
    if (done_cyc.size() >= 2)
      check("held_start_spacing", DW'(done_cyc[1] - done_cyc[0]), DW'(W + 2));
    else
      check("held_start_spacing", DW'(done_cyc.size()), 2);

    // Reset at T+2 aborts with no done pulse; start during reset is ignored.
    drive_start(77, 88, 1'b0, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    check("abort_busy", DW'(busy), 0);
    check("abort_sum", sum, 0);
    check("abort_done", DW'(done), 0);
    void'(exp_q.pop_back());
    @(posedge clk);
    #1 start = 1'b0; rst_n = 1'b1;
    d0 = n_done;
    repeat (10) @(posedge clk);
    #1;
    check("abort_no_done", DW'(n_done), DW'(d0));
    check("abort_idle_busy", DW'(busy), 0);

    run_op("after_abort", 3, 10, 1'b0, 1'b1);

    // WORDS=1 instance: done one edge after the start edge.
    @(negedge clk);
    a1 = 3; b1 = 10; cin1 = 1'b1; sub1 = 1'b0; start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    check("w1_busy", DW'(busy1), 1);
    check("w1_done_early", DW'(done1), 0);
    @(posedge clk);
    #1;
    check("w1_done", DW'(done1), 1);
    check("w1_sum", DW'(sum1), 14);
    check("w1_cout", DW'(cout1), 0);
    check("w1_ovf", DW'(ovf1), 0);
    @(posedge clk);
    #1;
    check("w1_done_fall", DW'(done1), 0);
    check("w1_busy_fall", DW'(busy1), 0);

    check("sb_empty", DW'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cla_mp_seq.md
# cla_mp_seq

Multi-precision add/subtract sequencer that time-shares a single 32-bit carry-lookahead adder across the limbs of a wide operand. It captures two WORDS×32-bit operands on a start request and feeds them limb by limb, least significant first, through one `cla32` instance, with the carry held in a register between limbs. It returns a wide sum, carry-out and signed overflow, with a start/busy/done handshake. It is the control layer that lets the 32-bit adder datapath serve 64/96/128-bit arithmetic without replicating the adder.

## Interface

Clock is `clk`. Reset is `rst_n`: synchronous, active-low.

Parameters:
- `WORDS`, default 4: number of 32-bit limbs. Legal range is 1..16.

Ports:
- `clk`, in, 1: rising-edge clock.
- `rst_n`, in, 1: synchronous active-low reset.
- `start`, in, 1: request. Sampled only in IDLE.
- `sub`, in, 1: 0 computes A+B+cin; 1 computes A−B, i.e. A+~B+1 with `cin` ignored.
- `cin`, in, 1: carry into limb 0 when `sub`=0.
- `a`, in, 32*WORDS: operand A. Captured on the accepted start.
- `b`, in, 32*WORDS: operand B. Captured on the accepted start.
- `busy`, out, 1: high whenever state ≠ IDLE.
- `done`, out, 1: one-cycle pulse when the result is valid.
- `sum`, out, 32*WORDS: result register.
- `cout`, out, 1: carry out of the top limb. For subtraction, 1 means no borrow.
- `ovf`, out, 1: two's-complement signed overflow of the full-width operation.

## Operation

FSM states are IDLE, RUN and DONE.
- **IDLE → RUN** on `start`=1.
  - Latch `a`, `b` and `sub` into operand registers.
  - Clear the limb index to 0.
  - Load the carry register with `sub ? 1 : cin`.
  - Clear `sum`, `cout` and `ovf`.
- **RUN**, each cycle:
  - Drive `cla32` with A limb[idx], B limb[idx] XOR {32{sub_q}}, and the carry register.
  - Write S to `sum` limb[idx] and the adder's Cout to the carry register.
  - Increment idx.
- **RUN → DONE** after the limb with idx = WORDS−1 is written.
  - At the same edge, `cout` takes the final carry.
  - At the same edge, `ovf` = (A_msb == B'_msb) && (S_msb ≠ A_msb), where B' is the possibly inverted B.
- **DONE → IDLE** unconditionally after one cycle. `done`=1 only in DONE.
- `start` in RUN or DONE is ignored and is not queued. Operand input changes after capture have no effect.
- `sum`, `cout` and `ovf` hold their values in IDLE until the next accepted start. During RUN, `sum` updates progressively and is not valid.
- Width rules:
  - All limb arithmetic is modulo 2^32.
  - The carry register is 1 bit.
  - idx is $clog2(WORDS) bits, minimum 1.
- WORDS=1 degenerates to one RUN cycle. The handshake and latency formula still apply.

## Timing

- Start sampled at edge T → RUN during cycles T+1..T+WORDS → `done` high in cycle T+WORDS+1 → IDLE at T+WORDS+2.
- Latency from start to done is WORDS+1 cycles. Throughput is one operation per WORDS+2 cycles.
- `busy` rises in cycle T+1 and falls in cycle T+WORDS+2, so it is high during DONE. `done` and `busy` are both registered outputs.
- Reset values: state IDLE; `busy`=0, `done`=0, `sum`=0, `cout`=0, `ovf`=0; idx and carry register 0.
- Reset mid-operation (`rst_n`=0 at any edge in RUN or DONE): abort immediately to reset values with no `done` pulse. A `start` in the same cycle as reset is ignored.
- `cla32` is purely combinational. The critical path runs from the operand/idx registers through the limb mux and `cla32` to the `sum`/carry registers. No extra pipeline stage is allowed.

## Structure

- Shared package `cla_pkg`:
  - `LIMB_W`=32.
  - State enum `cla_seq_state_t` {IDLE, RUN, DONE}.
  - Limb-select helper function.
- Sub-module: one instance of the existing `cla32` (ports A, B, Cin, S, Cout). There is no other hierarchy; limb muxing and FSM live in `cla_mp_seq`.

## Test plan

All scenarios use WORDS=4 unless noted.
- **Small add:** a=3, b=10, cin=1, sub=0, start at T → done pulse exactly at T+5, sum=14, cout=0, ovf=0, busy high T+1..T+5.
- **Inter-limb carry:** a=0x0000_0000_0000_0000_0000_0000_FFFF_FFFF, b=1, cin=0 → sum=0x1_0000_0000, cout=0.
- **Full wrap:** a=2^128−1, b=0, cin=1 → sum=0, cout=1, ovf=0. Also a=b=2^128−1, cin=1 → sum=2^128−1, cout=1.
- **Subtract:** a=7, b=5, sub=1 → sum=2, cout=1. Then a=5, b=7, sub=1 → sum=0xFFFF…FFFE, cout=0, ovf=0.
- **Signed overflow:** a=0x7FFF…FFFF, b=1, sub=0 → sum=0x8000…0000, ovf=1, cout=0.
- **Handshake robustness:**
  - `start` held high for 10 cycles → exactly one operation per WORDS+2 cycles, with no restart during RUN or DONE.
  - Operand changes during RUN do not alter the result.
  - `rst_n` low at T+2 → busy=0, sum=0, no done pulse.
  - A subsequent start completes normally.
  - Repeat the small-add case with WORDS=1 → done at T+2.
